// File: rtl/apb_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// apb_ctrl_pkg
// Shared types and helpers for the round-robin APB master.
//   apb_state_e : transfer sequencing states (IDLE, SETUP, ACCESS)
//   APB_ADDR_W  : default PADDR width
//   APB_DATA_W  : default PWDATA/PRDATA width
//   rr_pick()   : index of the first set request bit at or after a pointer,
//                 searching upward with wrap-around
// ----------------------------------------------------------------------------
package apb_ctrl_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // rr_pick works on a fixed-width view so it can live in the package;
    // callers zero-extend their request vector and pass the real count.
    localparam int RR_MAX_REQ = 8;
    localparam int RR_IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Returns the first set bit of req[n-1:0] at or after ptr, with wrap.
    // Returns 0 when no bit is set; callers qualify with |req.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [RR_IDX_W-1:0]   ptr,
        input int                    n
    );
        logic [RR_IDX_W-1:0] pick;
        logic                found;
        int                  idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && (i < n) && req[idx]) begin
                pick  = RR_IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The priority pointer is owned by the
// caller, which advances it after each accepted grant.
//   i_req         : request vector, one bit per requester
//   i_rr_ptr      : index that currently has highest priority
//   o_grant       : one-hot grant (all zero when nothing is requested)
//   o_grant_idx   : binary index of the granted requester
//   o_grant_valid : at least one request is pending
// ----------------------------------------------------------------------------
module rr_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_valid
);

    logic [RR_IDX_W-1:0] w_pick;

    assign w_pick        = rr_pick(RR_MAX_REQ'(i_req), RR_IDX_W'(i_rr_ptr), NUM_REQ);
    assign o_grant_idx   = IDX_W'(w_pick);
    assign o_grant_valid = |i_req;

    always_comb begin
        // NOTE: assign a default before any conditional write in always_comb,
        // otherwise paths that skip the assignment infer a latch.
        o_grant = '0;
        if (o_grant_valid) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// ----------------------------------------------------------------------------
// apb_rr_master
// Shares one APB bus among NUM_REQ requesters. Each requester posts a single
// read or write over valid/ready; the block arbitrates round-robin, runs the
// APB SETUP/ACCESS phases, waits for PREADY (bounded by TIMEOUT) and returns
// read data or a timeout error to the granted requester.
//   PCLK, PRESETn          : clock, synchronous active-low reset
//   req_valid/req_write    : per-requester request and direction (1 = write)
//   req_addr/req_wdata     : packed per-requester address and write data
//   req_ready              : one-hot accept, only while IDLE and out of reset
//   rsp_valid              : one-hot, one-cycle completion pulse
//   rsp_rdata/rsp_err      : shared response data / timeout flag
//   PADDR..PWDATA          : APB master outputs
//   PRDATA, PREADY         : APB slave responses
// ----------------------------------------------------------------------------
module apb_rr_master
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort when the current PREADY-low cycle would bring the count to TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    apb_state_e          r_state;
    apb_state_e          w_state_nxt;
    logic                r_psel;
    logic                r_penable;
    logic                w_psel_nxt;
    logic                w_penable_nxt;

    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_gidx;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_pwrite;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_grant_valid;
    logic                w_idle;
    logic                w_handshake;
    logic                w_done_ok;
    logic                w_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req         (req_valid),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // Acceptance is only offered while idle and out of reset, so a request
    // is never consumed on an edge that is about to reset the block.
    assign w_idle      = PRESETn && (r_state == IDLE);
    assign req_ready   = w_idle ? w_grant : '0;
    assign w_handshake = w_idle && w_grant_valid;
    assign w_done_ok   = (r_state == ACCESS) && PREADY;
    assign w_timeout   = (TIMEOUT != 0) && (r_state == ACCESS) && !PREADY
                         && (r_wait_cnt == CNT_LAST);

    // Next state plus next PSEL/PENABLE, so the bus strobes come straight
    // from flops rather than from a state decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = SETUP;
                    w_psel_nxt  = 1'b1;
                end
            end
            SETUP: begin
                w_state_nxt   = ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (w_done_ok || w_timeout) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_rr_ptr    <= '0;
            r_gidx      <= '0;
            r_wait_cnt  <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;

            // Request fields are captured once and then held unchanged
            // through SETUP, ACCESS and the following idle period.
            if (w_handshake) begin
                r_paddr    <= req_addr[w_grant_idx*ADDR_W +: ADDR_W];
                r_pwdata   <= req_wdata[w_grant_idx*DATA_W +: DATA_W];
                r_pwrite   <= req_write[w_grant_idx];
                r_gidx     <= w_grant_idx;
                r_rr_ptr   <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                   : w_grant_idx + 1'b1;
                r_wait_cnt <= '0;
            end

            if ((r_state == ACCESS) && !PREADY) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_done_ok) begin
                r_rsp_valid <= NUM_REQ'(1) << r_gidx;
                r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                r_rsp_err   <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_valid <= NUM_REQ'(1) << r_gidx;
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PWRITE    = r_pwrite;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_rr_master.sv
// ----------------------------------------------------------------------------
// tb_apb_rr_master
// Directed bench for apb_rr_master (NUM_REQ=4, TIMEOUT=16). A cycle table
// covers reset, a zero-wait write, a wait-state read and round-robin
// fairness; hand-written sequences cover timeout, back-to-back reissue and
// reset during ACCESS. Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_apb_rr_master;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [ADDR_W-1:0]         paddr;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [DATA_W-1:0]         pwdata;
    logic [DATA_W-1:0]         prdata;
    logic                      pready;

    always #5 clk = ~clk;

    apb_rr_master #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK      (clk),
        .PRESETn   (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (paddr),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PWDATA    (pwdata),
        .PRDATA    (prdata),
        .PREADY    (pready)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [3:0]  write;
        logic        pready;
        logic [31:0] prdata;
        logic [3:0]  e_ready;
        logic        e_psel;
        logic        e_pen;
        logic [3:0]  e_rsp;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_paddr;
        logic        e_pwrite;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus cycle: drive inputs just after the edge, sample at the falling edge.
    task automatic cycle(input logic r, input logic [3:0] v, input logic [3:0] w,
                         input logic rdy, input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst_n     = r;
        req_valid = v;
        req_write = w;
        pready    = rdy;
        prdata    = rd;
        @(negedge clk);
    endtask

    task automatic chk_bus(input string tag, input logic [3:0] e_ready, input logic e_psel,
                           input logic e_pen, input logic [3:0] e_rsp);
        check({tag, " req_ready"}, req_ready, e_ready);
        check({tag, " PSEL"},      psel,      e_psel);
        check({tag, " PENABLE"},   penable,   e_pen);
        check({tag, " rsp_valid"}, rsp_valid, e_rsp);
    endtask

    task automatic add_vec(input logic r, input logic [3:0] v, input logic [3:0] w,
                           input logic rdy, input logic [31:0] rd,
                           input logic [3:0] e_ready, input logic e_psel, input logic e_pen,
                           input logic [3:0] e_rsp, input logic e_err, input logic [31:0] e_rdata,
                           input logic [31:0] e_paddr, input logic e_pwrite);
        vec_t x;
        x.rst_n = r;        x.valid = v;        x.write = w;
        x.pready = rdy;     x.prdata = rd;      x.e_ready = e_ready;
        x.e_psel = e_psel;  x.e_pen = e_pen;    x.e_rsp = e_rsp;
        x.e_err = e_err;    x.e_rdata = e_rdata; x.e_paddr = e_paddr;
        x.e_pwrite = e_pwrite;
        vecs.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t t;

        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        pready    = 1'b0;
        prdata    = '0;
        req_addr  = {32'h0000_0030, 32'h0000_0010, 32'h0000_0020, 32'h0000_0004};
        req_wdata = {32'hCAFE_0003, 32'hA5A5_0001, 32'h1234_5678, 32'h0000_00F0};

        //      rst valid    write    rdy prdata          ready   ps pe rsp     er rdata         paddr         pw
        // Reset: ready gated low even with a request pending.
        add_vec(0, 4'b0100, 4'b0100, 1, 32'h0,          4'b0000, 0, 0, 4'b0000, 0, 32'h0,        32'h00, 0);
        // Single zero-wait write from requester 2.
        add_vec(1, 4'b0100, 4'b0100, 1, 32'h0,          4'b0100, 0, 0, 4'b0000, 0, 32'h0,        32'h00, 0);
        add_vec(1, 4'b0000, 4'b0000, 1, 32'h0,          4'b0000, 1, 0, 4'b0000, 0, 32'h0,        32'h10, 1);
        add_vec(1, 4'b0000, 4'b0000, 1, 32'hFFFF_FFFF,  4'b0000, 1, 1, 4'b0000, 0, 32'h0,        32'h10, 1);
        add_vec(1, 4'b0001, 4'b0000, 0, 32'h0,          4'b0001, 0, 0, 4'b0100, 0, 32'h0,        32'h10, 1);
        // Read from requester 0 with three wait states.
        add_vec(1, 4'b0000, 4'b0000, 0, 32'h0,          4'b0000, 1, 0, 4'b0000, 0, 32'h0,        32'h04, 0);
        add_vec(1, 4'b0000, 4'b0000, 0, 32'h0,          4'b0000, 1, 1, 4'b0000, 0, 32'h0,        32'h04, 0);
        add_vec(1, 4'b0000, 4'b0000, 0, 32'h0,          4'b0000, 1, 1, 4'b0000, 0, 32'h0,        32'h04, 0);
        add_vec(1, 4'b0000, 4'b0000, 0, 32'h0,          4'b0000, 1, 1, 4'b0000, 0, 32'h0,        32'h04, 0);
        add_vec(1, 4'b0000, 4'b0000, 1, 32'h2A,         4'b0000, 1, 1, 4'b0000, 0, 32'h0,        32'h04, 0);
        add_vec(1, 4'b0000, 4'b0000, 0, 32'h0,          4'b0000, 0, 0, 4'b0001, 0, 32'h2A,       32'h04, 0);
        // Fairness: reset, then all four request continuously.
        add_vec(0, 4'b1111, 4'b0000, 1, 32'h55,         4'b0000, 0, 0, 4'b0000, 0, 32'h0,        32'h04, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b0001, 0, 0, 4'b0000, 0, 32'h0,        32'h00, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b0000, 1, 0, 4'b0000, 0, 32'h0,        32'h04, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b0000, 1, 1, 4'b0000, 0, 32'h0,        32'h04, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b0010, 0, 0, 4'b0001, 0, 32'h55,       32'h04, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b0000, 1, 0, 4'b0000, 0, 32'h0,        32'h20, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b0000, 1, 1, 4'b0000, 0, 32'h0,        32'h20, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b0100, 0, 0, 4'b0010, 0, 32'h55,       32'h20, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b0000, 1, 0, 4'b0000, 0, 32'h0,        32'h10, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b0000, 1, 1, 4'b0000, 0, 32'h0,        32'h10, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b1000, 0, 0, 4'b0100, 0, 32'h55,       32'h10, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b0000, 1, 0, 4'b0000, 0, 32'h0,        32'h30, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b0000, 1, 1, 4'b0000, 0, 32'h0,        32'h30, 0);
        add_vec(1, 4'b1111, 4'b0000, 1, 32'h55,         4'b0001, 0, 0, 4'b1000, 0, 32'h55,       32'h30, 0);
        add_vec(1, 4'b0000, 4'b0000, 1, 32'h55,         4'b0000, 1, 0, 4'b0000, 0, 32'h0,        32'h04, 0);
        add_vec(1, 4'b0000, 4'b0000, 1, 32'h55,         4'b0000, 1, 1, 4'b0000, 0, 32'h0,        32'h04, 0);
        add_vec(1, 4'b0000, 4'b0000, 0, 32'h0,          4'b0000, 0, 0, 4'b0001, 0, 32'h55,       32'h04, 0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            cycle(t.rst_n, t.valid, t.write, t.pready, t.prdata);
            chk_bus($sformatf("v%0d", i), t.e_ready, t.e_psel, t.e_pen, t.e_rsp);
            check($sformatf("v%0d PADDR", i),  paddr,  t.e_paddr);
            check($sformatf("v%0d PWRITE", i), pwrite, t.e_pwrite);
            if (t.e_rsp != 4'b0000) begin
                check($sformatf("v%0d rsp_err", i),   rsp_err,   t.e_err);
                check($sformatf("v%0d rsp_rdata", i), rsp_rdata, t.e_rdata);
            end
        end

        // Timeout: requester 3 reads, PREADY stuck low; abort 17 cycles after SETUP.
        cycle(1, 4'b1000, 4'b0000, 0, 32'hDEAD_BEEF);
        chk_bus("to hs", 4'b1000, 0, 0, 4'b0000);
        cycle(1, 4'b0000, 4'b0000, 0, 32'hDEAD_BEEF);
        chk_bus("to setup", 4'b0000, 1, 0, 4'b0000);
        check("to setup PADDR", paddr, 32'h30);
        for (int k = 1; k <= TIMEOUT; k++) begin
            cycle(1, 4'b0000, 4'b0000, 0, 32'hDEAD_BEEF);
            chk_bus($sformatf("to wait%0d", k), 4'b0000, 1, 1, 4'b0000);
            check($sformatf("to wait%0d PADDR", k), paddr, 32'h30);
        end
        // Abort cycle; requester 1 posts a write right away.
        cycle(1, 4'b0010, 4'b0010, 1, 32'h0);
        chk_bus("to abort", 4'b0010, 0, 0, 4'b1000);
        check("to abort rsp_err",   rsp_err,   1'b1);
        check("to abort rsp_rdata", rsp_rdata, 32'h0);

        // Post-timeout write proceeds normally, then requester 1 reissues a
        // read in the same cycle as its response.
        cycle(1, 4'b0000, 4'b0000, 1, 32'h0);
        chk_bus("b2b setup", 4'b0000, 1, 0, 4'b0000);
        check("b2b setup PADDR",  paddr,  32'h20);
        check("b2b setup PWRITE", pwrite, 1'b1);
        check("b2b setup PWDATA", pwdata, 32'h1234_5678);
        cycle(1, 4'b0000, 4'b0000, 1, 32'h0);
        chk_bus("b2b access", 4'b0000, 1, 1, 4'b0000);
        cycle(1, 4'b0010, 4'b0000, 1, 32'h77);
        chk_bus("b2b rsp", 4'b0010, 0, 0, 4'b0010);
        check("b2b rsp rsp_err",   rsp_err,   1'b0);
        check("b2b rsp rsp_rdata", rsp_rdata, 32'h0);
        cycle(1, 4'b0000, 4'b0000, 1, 32'h77);
        chk_bus("b2b setup2", 4'b0000, 1, 0, 4'b0000);
        check("b2b setup2 PWRITE", pwrite, 1'b0);
        cycle(1, 4'b0000, 4'b0000, 1, 32'h77);
        chk_bus("b2b access2", 4'b0000, 1, 1, 4'b0000);
        // Requester 0 starts the transfer that will be cut by reset.
        cycle(1, 4'b0001, 4'b0000, 0, 32'h0);
        chk_bus("b2b rsp2", 4'b0001, 0, 0, 4'b0010);
        check("b2b rsp2 rsp_rdata", rsp_rdata, 32'h77);

        // Reset for one cycle during ACCESS; transfer discarded, requester 0
        // wins first after release even though requester 1 is also pending.
        cycle(1, 4'b0000, 4'b0000, 0, 32'h0);
        chk_bus("rst setup", 4'b0000, 1, 0, 4'b0000);
        check("rst setup PADDR", paddr, 32'h04);
        cycle(0, 4'b0011, 4'b0000, 0, 32'h0);
        chk_bus("rst access", 4'b0000, 1, 1, 4'b0000);
        cycle(1, 4'b0011, 4'b0000, 1, 32'h0);
        chk_bus("rst after", 4'b0001, 0, 0, 4'b0000);
        check("rst after PADDR", paddr, 32'h0);
        cycle(1, 4'b0010, 4'b0000, 1, 32'h99);
        chk_bus("rst setup2", 4'b0000, 1, 0, 4'b0000);
        check("rst setup2 PADDR", paddr, 32'h04);
        cycle(1, 4'b0010, 4'b0000, 1, 32'h99);
        chk_bus("rst access2", 4'b0000, 1, 1, 4'b0000);
        cycle(1, 4'b0010, 4'b0000, 1, 32'h0);
        chk_bus("rst done", 4'b0010, 0, 0, 4'b0001);
        check("rst done rsp_rdata", rsp_rdata, 32'h99);
        cycle(1, 4'b0000, 4'b0000, 1, 32'h0);
        chk_bus("rst next", 4'b0000, 1, 0, 4'b0000);
        check("rst next PADDR", paddr, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Round-robin APB master that shares one APB bus among `NUM_REQ` internal requesters. Each requester posts a single read or write over a valid/ready handshake. The block arbitrates among pending requests, sequences the APB SETUP and ACCESS phases, waits for `PREADY`, and returns read data or a timeout error to the requester it granted. It drives the master side of `apb_if` and sits between the test/CPU-side request agents and the counter IP slave.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 32: PADDR width.
- `DATA_W`, 32: PWDATA/PRDATA width.
- `TIMEOUT`, 16: maximum number of ACCESS cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- `PCLK` in 1: the single clock.
- `PRESETn` in 1: reset, synchronous and active-low.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*ADDR_W: packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- `req_wdata` in NUM_REQ*DATA_W: packed write data.
- `req_ready` out NUM_REQ: one-hot accept.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle completion pulse.
- `rsp_rdata` out DATA_W: read data, shared across requesters. Valid only with `rsp_valid`.
- `rsp_err` out 1: timeout flag. Valid only with `rsp_valid`.
- `PADDR` out 32, `PSEL` out 1, `PENABLE` out 1, `PWRITE` out 1, `PWDATA` out 32: APB master outputs.
- `PRDATA` in 32, `PREADY` in 1: APB slave responses.

## Operation
- FSM states are IDLE, SETUP and ACCESS. The reset state is IDLE.
- **IDLE**
  - The arbiter picks grant g: the first set `req_valid` bit, searching upward (with wrap) from `rr_ptr`.
  - `req_ready[g]` = 1 combinationally. All other `req_ready` bits are 0. `req_ready` is 0 whenever PRESETn = 0.
  - A handshake completes on a rising edge where `req_valid[g]` and `req_ready[g]` are both 1.
  - On that edge the block latches addr/wdata/write for g into PADDR/PWDATA/PWRITE, sets `rr_ptr` = (g+1) mod NUM_REQ, and moves to SETUP.
  - With no `req_valid` bits set, the block stays in IDLE.
- **SETUP**
  - PSEL = 1, PENABLE = 0.
  - Always moves to ACCESS on the next edge.
- **ACCESS**
  - PSEL = 1, PENABLE = 1. The wait counter increments on every cycle where PREADY = 0.
  - PREADY = 1: on that edge, capture `rsp_rdata` = PRDATA for a read or 0 for a write. Set `rsp_err` = 0 and pulse `rsp_valid[g]`. Go to IDLE.
  - Wait counter reaches TIMEOUT (TIMEOUT ≠ 0) with PREADY still 0: set `rsp_rdata` = 0 and `rsp_err` = 1, pulse `rsp_valid[g]`, go to IDLE.
- PADDR, PWDATA and PWRITE are stable from SETUP through the end of ACCESS. They hold their last values while IDLE.
- PSEL and PENABLE are registered and glitch-free.
- Requesters that are not granted keep `req_valid` asserted and wait. A requester must not drop `req_valid` before its handshake completes.
- Reset value of every output is 0: PADDR, PWDATA, PWRITE, PSEL, PENABLE, `rsp_valid`, `rsp_rdata`, `rsp_err`. The internal `rr_ptr` and wait counter also reset to 0.
- Reset asserted mid-transfer: at the next edge, PSEL and PENABLE drop to 0 and the state returns to IDLE. No `rsp_valid` is issued and the transfer is discarded.

## Timing
- Zero-wait transfer:
  - Cycle 0: IDLE handshake.
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS with PREADY = 1.
  - Cycle 3: `rsp_valid` = 1, state IDLE, and the next handshake is possible in the same cycle.
- Throughput is one transfer per 3 cycles, plus one cycle per PREADY-low ACCESS cycle.
- Timeout: `rsp_valid` with `rsp_err` = 1 appears TIMEOUT + 1 cycles after SETUP. PSEL is low in that same cycle.
- `rsp_valid` is exactly one cycle wide and never overlaps a SETUP or ACCESS cycle of the same transfer.
- Wait counter width is clog2(TIMEOUT+1). It clears on entry to SETUP.

## Structure
- Package `apb_ctrl_pkg` holds:
  - `apb_state_e` enum {IDLE, SETUP, ACCESS};
  - the ADDR_W/DATA_W default constants;
  - a `rr_pick` function returning the index of the first set bit at or after a pointer, with wrap.
- Sub-module `rr_arbiter`: combinational, parameterised by NUM_REQ. Inputs are the request vector and `rr_ptr`. Outputs are the one-hot grant and its index. The top level owns `rr_ptr`.
- The top level holds the FSM, APB output registers, wait counter and response registers.

## Test plan
- **Single write:** req 2 writes addr 0x10, data 0xA5A5_0001, PREADY tied 1 → `req_ready[2]` in cycle 0; PSEL=1/PENABLE=0 in cycle 1; PENABLE=1 in cycle 2; `rsp_valid[2]` with `rsp_err`=0 and `rsp_rdata`=0 in cycle 3.
- **Wait-state read:** req 0 reads 0x04 while the slave holds PREADY low for 3 ACCESS cycles and then returns PRDATA=0x0000_002A → PADDR/PSEL stable throughout; `rsp_rdata`=0x2A and `rsp_valid[0]` one cycle after PREADY.
- **Fairness:** all 4 requesters hold `req_valid` continuously after reset → grant order 0,1,2,3,0,… with exactly one handshake per 3 cycles.
- **Timeout:** TIMEOUT=16, PREADY stuck 0 → `rsp_valid[g]` with `rsp_err`=1 and `rsp_rdata`=0 at 17 cycles after SETUP; PSEL=0 in that cycle; the next request then proceeds normally.
- **Reset mid-ACCESS:** PRESETn=0 for one cycle during ACCESS → PSEL/PENABLE/`rsp_valid` all 0 after the edge; no response issued; after release, requester 0 wins first.
- **Back-to-back:** req 1 reasserts `req_valid` in the same cycle as its `rsp_valid` → a new handshake completes in that cycle; no idle bubble beyond the IDLE cycle.
